// File: rtl/fsm_ctl_pkg.sv
// Shared types and sizes for the fsm_exp request scheduler.
package fsm_ctl_pkg;

    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 2;
    localparam int IDX_W   = 2;
    localparam int RSP_W   = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } sched_state_t;

    // Pull requester idx's code out of the packed per-requester code bus.
    function automatic logic [CODE_W-1:0] code_of(
        input logic [NUM_REQ*CODE_W-1:0] codes,
        input logic [IDX_W-1:0]          idx
    );
        return codes[idx*CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/fsm_req_scheduler_rr_arb4.sv
// Combinational 4-way round-robin arbiter: the search starts one past the
// previous winner, so the previous winner is always lowest priority.
module rr_arb4
    import fsm_ctl_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan requesters in rotated order and keep the first one that is set.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'(i_last + IDX_W'(k));
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_req_scheduler.sv
// Shares one fsm_exp among four requesters: grants one requester, holds its
// code on the FSM inputs for HOLD_CYCLES+1 cycles, then returns the FSM's
// combinational result to that requester. All outputs are registered.
module fsm_req_scheduler
    import fsm_ctl_pkg::*;
#(
    // Cycles the granted code sits on the FSM before sampling; legal 1..15.
    parameter int unsigned       HOLD_CYCLES = 2,
    parameter logic [CODE_W-1:0] IDLE_CODE   = 2'b00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CODE_W-1:0]  req_code,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [0:CODE_W-1]          fsm_state_inputs,
    input  logic [RSP_W-1:0]           fsm_comb_outputs,
    output logic                       rsp_valid,
    output logic [IDX_W-1:0]           rsp_id,
    output logic [RSP_W-1:0]           rsp_data
);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;

    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_busy;
    logic [CODE_W-1:0]    r_code;
    logic                 r_rsp_valid;
    logic [IDX_W-1:0]     r_rsp_id;
    logic [RSP_W-1:0]     r_rsp_data;

    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic                 w_busy_nxt;
    logic [CODE_W-1:0]    w_code_nxt;
    logic                 w_rsp_valid_nxt;
    logic [IDX_W-1:0]     w_rsp_id_nxt;
    logic [RSP_W-1:0]     w_rsp_data_nxt;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_any;

    rr_arb4 u_arb (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, count down in DRIVE, one SAMPLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_any) w_state_nxt = DRIVE;
            DRIVE:   if (r_cnt == '0) w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs, counter and priority pointer.
    always_comb begin
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_code_nxt      = r_code;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_data_nxt  = r_rsp_data;
        case (r_state)
            IDLE: begin
                w_code_nxt = IDLE_CODE;
                if (w_arb_any) begin
                    // req_code is only looked at here; later changes are ignored.
                    w_gnt_nxt  = w_arb_gnt;
                    w_busy_nxt = 1'b1;
                    w_code_nxt = code_of(req_code, w_arb_idx);
                    w_last_nxt = w_arb_idx;
                    w_cnt_nxt  = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            DRIVE: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
            end
            SAMPLE: begin
                w_rsp_data_nxt  = fsm_comb_outputs;
                w_rsp_id_nxt    = r_last;
                w_rsp_valid_nxt = 1'b1;
                w_code_nxt      = IDLE_CODE;
                w_busy_nxt      = 1'b0;
            end
            default: begin
                w_code_nxt = IDLE_CODE;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output, counter and pointer registers; pointer resets to 3 so requester 0 leads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_code      <= IDLE_CODE;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_gnt       <= w_gnt_nxt;
            r_busy      <= w_busy_nxt;
            r_code      <= w_code_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    // The code's upper bit (req_code[2i+1]) lands on fsm_state_inputs[0].
    assign fsm_state_inputs = r_code;
    assign gnt              = r_gnt;
    assign busy             = r_busy;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_id           = r_rsp_id;
    assign rsp_data         = r_rsp_data;

endmodule

// File: tb/tb_fsm_req_scheduler.sv
// Bench for fsm_req_scheduler: two instances (default and HOLD_CYCLES=1 /
// IDLE_CODE=2'b11) share stimulus and are each checked every cycle against
// a transaction-level model, plus directed spot checks.
module tb_fsm_req_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] req_code;

    logic [3:0] gnt0, gnt1;
    logic       busy0, busy1;
    logic [0:1] si0, si1;
    logic [3:0] co0, co1;
    logic       rv0, rv1;
    logic [1:0] id0, id1;
    logic [3:0] data0, data1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state per instance
    int         m_hold [2];
    logic [1:0] m_idle [2];
    bit         g_valid[2];
    int         g_edge [2];
    int         g_id   [2];
    logic [1:0] g_code [2];
    int         m_last [2];
    logic [1:0] r_id   [2];
    logic [3:0] r_data [2];

    int gq[$];

    // Stand-in for fsm_exp's combinational output as a function of its inputs.
    function automatic logic [3:0] fsm_tab(input logic [1:0] c);
        case (c)
            2'b00:   return 4'h3;
            2'b01:   return 4'h6;
            2'b10:   return 4'hA;
            default: return 4'hC;
        endcase
    endfunction

    assign co0 = fsm_tab(si0);
    assign co1 = fsm_tab(si1);

    fsm_req_scheduler u_dut0 (
        .clk(clk), .reset(reset), .req(req), .req_code(req_code),
        .gnt(gnt0), .busy(busy0), .fsm_state_inputs(si0),
        .fsm_comb_outputs(co0), .rsp_valid(rv0), .rsp_id(id0), .rsp_data(data0)
    );

    fsm_req_scheduler #(.HOLD_CYCLES(1), .IDLE_CODE(2'b11)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .req_code(req_code),
        .gnt(gnt1), .busy(busy1), .fsm_state_inputs(si1),
        .fsm_comb_outputs(co1), .rsp_valid(rv1), .rsp_id(id1), .rsp_data(data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        g_valid[d] = 1'b0;
        g_edge[d]  = 0;
        g_id[d]    = 0;
        g_code[d]  = 2'b00;
        m_last[d]  = 3;
        r_id[d]    = 2'b00;
        r_data[d]  = 4'h0;
    endtask

    // One clock edge of the scheduler, described as transactions: a grant at
    // edge E owns the FSM through E+H, responds at E+H+1, and the next
    // arbitration may happen from edge E+H+2 onward.
    task automatic model_edge(input int d);
        int w;
        if (g_valid[d] && cyc == g_edge[d] + m_hold[d] + 1) begin
            r_id[d]   = 2'(g_id[d]);
            r_data[d] = fsm_tab(g_code[d]);
        end
        if ((!g_valid[d] || cyc >= g_edge[d] + m_hold[d] + 2) && req != 4'b0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
            end
            g_valid[d] = 1'b1;
            g_edge[d]  = cyc;
            g_id[d]    = w;
            g_code[d]  = req_code[2*w +: 2];
            m_last[d]  = w;
        end
    endtask

    task automatic compare(input int d, input logic [3:0] g, input logic b,
                           input logic [1:0] c, input logic v,
                           input logic [1:0] id, input logic [3:0] dt);
        bit         win;
        logic [3:0] eg;
        win = g_valid[d] && cyc >= g_edge[d] && cyc <= g_edge[d] + m_hold[d];
        eg  = (g_valid[d] && cyc == g_edge[d]) ? (4'b0001 << g_id[d]) : 4'b0000;
        check($sformatf("d%0d_gnt", d), 32'(g), 32'(eg));
        check($sformatf("d%0d_busy", d), 32'(b), 32'(win));
        check($sformatf("d%0d_code", d), 32'(c), win ? 32'(g_code[d]) : 32'(m_idle[d]));
        check($sformatf("d%0d_rsp_valid", d), 32'(v),
              32'(g_valid[d] && cyc == g_edge[d] + m_hold[d] + 1));
        check($sformatf("d%0d_rsp_id", d), 32'(id), 32'(r_id[d]));
        check($sformatf("d%0d_rsp_data", d), 32'(dt), 32'(r_data[d]));
    endtask

    task automatic compare_all();
        compare(0, gnt0, busy0, si0, rv0, id0, data0);
        compare(1, gnt1, busy1, si1, rv1, id1, data1);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) model_reset(d);
            else       model_edge(d);
        end
        #1;
        compare_all();
    endtask

    // Assert reset between edges, check the asynchronous clear at once,
    // hold it across two edges, then release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        m_hold[0] = 2;     m_hold[1] = 1;
        m_idle[0] = 2'b00; m_idle[1] = 2'b11;
        model_reset(0);
        model_reset(1);
        reset    = 1'b1;
        req      = 4'b0;
        req_code = 8'h00;
        #2;
        compare_all();
        check("rst_idle_code1", 32'(si1), 32'h3);
        step();
        step();
        reset = 1'b0;
        step();

        // Single request from requester 0, code 2'b10
        req = 4'b0001; req_code = 8'h02;
        step();
        check("single_gnt", 32'(gnt0), 32'h1);
        check("single_code_e0", 32'(si0), 32'h2);
        req = 4'b0000;
        step();
        check("single_code_e1", 32'(si0), 32'h2);
        step();
        check("single_code_e2", 32'(si0), 32'h2);
        check("single_no_rsp_e2", 32'(rv0), 32'h0);
        step();
        check("single_rsp_valid", 32'(rv0), 32'h1);
        check("single_rsp_id", 32'(id0), 32'h0);
        check("single_rsp_data", 32'(data0), 32'hA);
        check("single_busy_low", 32'(busy0), 32'h0);
        step();
        check("single_rsp_hold", 32'(data0), 32'hA);

        // All four requesting continuously
        do_reset();
        req = 4'b1111; req_code = 8'h39;
        gq.delete();
        for (int i = 0; i < 20; i++) begin
            step();
            for (int k = 0; k < 4; k++) if (gnt0[k]) gq.push_back(k);
        end
        check("rr_count", 32'(gq.size() >= 5), 32'h1);
        for (int k = 0; k < 5 && k < gq.size(); k++)
            check($sformatf("rr_order%0d", k), 32'(gq[k]), 32'(k % 4));

        // Late arrival of requester 2 during requester 0's DRIVE
        req = 4'b0000;
        do_reset();
        req = 4'b0001; req_code = 8'h00;
        step();
        check("fair_gnt0", 32'(gnt0), 32'h1);
        step();
        req = 4'b0101;
        step();
        step();
        step();
        check("fair_gnt2", 32'(gnt0), 32'h4);
        for (int i = 0; i < 4; i++) step();
        check("fair_gnt0_again", 32'(gnt0), 32'h1);

        // Reset mid-DRIVE
        req = 4'b0000;
        do_reset();
        req = 4'b0010; req_code = 8'h0C;
        step();
        req = 4'b0000;
        step();
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy0), 32'h0);
        check("midrst_code", 32'(si0), 32'h0);
        model_reset(0);
        model_reset(1);
        compare_all();
        step();
        check("midrst_no_rsp", 32'(rv0), 32'h0);
        step();
        reset = 1'b0;
        req = 4'b0011;
        step();
        check("midrst_first_gnt", 32'(gnt0), 32'h1);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) step();

        // HOLD_CYCLES=1 / IDLE_CODE=2'b11 instance, requester 3 code 2'b01
        do_reset();
        req = 4'b1000; req_code = 8'h40;
        step();
        check("h1_gnt", 32'(gnt1), 32'h8);
        check("h1_code_e0", 32'(si1), 32'h1);
        req = 4'b0000;
        step();
        check("h1_code_e1", 32'(si1), 32'h1);
        step();
        check("h1_rsp_valid", 32'(rv1), 32'h1);
        check("h1_rsp_data", 32'(data1), 32'h6);
        check("h1_idle_code", 32'(si1), 32'h3);

        // Code change after grant and early drop
        do_reset();
        req = 4'b0100; req_code = 8'h30;
        step();
        req_code = 8'h10; req = 4'b0000;
        step();
        step();
        step();
        check("drop_rsp_valid", 32'(rv0), 32'h1);
        check("drop_rsp_id", 32'(id0), 32'h2);
        check("drop_rsp_data", 32'(data0), 32'hC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            req_code = 8'($urandom);
            if ($urandom_range(0, 63) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
